uart_rx_ctrl: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 65 ++++++
 rtl/uart_rx_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FIFO geometry and status byte layout.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_PTR_W = 4;
  localparam int unsigned FIFO_CNT_W = 5;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_CNT_LSB   = 3;

  // Assemble the status byte from its fields.
  function automatic logic [7:0] packStatus(input logic [FIFO_CNT_W-1:0] count,
                                            input logic overrun,
                                            input logic full,
                                            input logic notEmpty);
    logic [7:0] s;
    s = '0;
    s[ST_CNT_LSB +: FIFO_CNT_W] = count;
    s[ST_OVERRUN]               = overrun;
    s[ST_FULL]                  = full;
    s[ST_NOT_EMPTY]             = notEmpty;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// 16-entry receive FIFO with occupancy count; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it is reported as a drop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = uart_pkg::DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      dataIn,
  output logic [WIDTH-1:0]      dataOut,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  popAck,
  output logic                  drop
);

  logic [WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wrPtrQ, wrPtrD;
  logic [FIFO_PTR_W-1:0] rdPtrQ, rdPtrD;
  logic [FIFO_CNT_W-1:0] countQ, countD;
  logic                  pushOk;

  assign full    = (countQ == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty   = (countQ == '0);
  assign count   = countQ;
  assign popAck  = pop & ~empty;
  assign pushOk  = push & (~full | popAck);
  assign drop    = push & ~pushOk;
  assign dataOut = mem[rdPtrQ];

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (pushOk) wrPtrD = wrPtrQ + 1'b1;
    if (popAck) rdPtrD = rdPtrQ + 1'b1;
    unique case ({pushOk, popAck})
      2'b10:   countD = countQ + 1'b1;
      2'b01:   countD = countQ - 1'b1;
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  // Storage needs no reset: a cleared count makes every entry unreachable.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtrQ] <= dataIn;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generator, receive FIFO, registered pop and status.
// Optional sticky overrun flag is built when UART_RX_OVERRUN_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baudDiv,
  output logic                 sTick,
  input  logic                 rxDoneTick,
  input  logic [DATA_BITS-1:0] rxData,
  input  logic                 rdReq,
  output logic [DATA_BITS-1:0] rdData,
  output logic                 rdValid,
  input  logic                 statRd,
  output logic [7:0]           statusOut
);

  import uart_pkg::*;

  logic [DIV_W-1:0]      divCnt;
  logic [DATA_BITS-1:0]  fifoData;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [FIFO_CNT_W-1:0] fifoCount;
  logic                  popAck;
  logic                  drop;
  logic                  overrunQ;
  logic [7:0]            statusD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
      sTick  <= 1'b0;
    end else if (divCnt == baudDiv) begin
      divCnt <= '0;
      sTick  <= 1'b1;
    end else begin
      divCnt <= divCnt + 1'b1;
      sTick  <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS)
  ) uRxFifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rxDoneTick),
    .pop     (rdReq),
    .dataIn  (rxData),
    .dataOut (fifoData),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount),
    .popAck  (popAck),
    .drop    (drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= popAck;
      if (popAck) rdData <= fifoData;
    end
  end

`ifdef UART_RX_OVERRUN_EN
  logic overrunD;

  // A drop in the same cycle as a status read keeps the flag set.
  always_comb begin
    overrunD = overrunQ;
    if (drop)        overrunD = 1'b1;
    else if (statRd) overrunD = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrunQ <= 1'b0;
    else       overrunQ <= overrunD;
  end
`else
  logic unusedOverrunInputs;

  assign overrunQ            = 1'b0;
  assign unusedOverrunInputs = drop ^ statRd;
`endif

  assign statusD = packStatus(fifoCount, overrunQ, fifoFull, ~fifoEmpty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) statusOut <= 8'h00;
    else       statusOut <= statusD;
  end

endmodule
